// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_arb_pkg
// Purpose  : Shared constants for the instruction-memory read-port arbiter:
//            port indices, response-slot states and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    // Default address / data widths
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Port indices (also the encoding of the round-robin last-grant bit)
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Response slot state encoding
    localparam logic RESP_EMPTY = 1'b0;
    localparam logic RESP_FULL  = 1'b1;

    // Width of the anti-starvation wait counter (holds MAX_WAIT up to 15)
    localparam int WAIT_CW = 4;

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_resp_buf.sv
`default_nettype none
// ============================================================================
// Module   : imem_resp_buf
// Purpose  : One registered response slot (EMPTY/FULL) with valid/ready
//            handshake. A load in the same cycle as a drain replaces the
//            old response with the new one, so there is no bubble.
// Revision : 1.0 - initial release
// ============================================================================
module imem_resp_buf
    import imem_arb_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_err,
    input  logic          rready,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          err
);

    logic          r_state;
    logic          w_state_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          r_err;
    logic          w_err_nxt;

    // State register: slot state plus its payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESP_EMPTY;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next state: a new grant loads, an accepted response clears, else hold
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        if (load) begin
            w_state_nxt = RESP_FULL;
            w_data_nxt  = load_data;
            w_err_nxt   = load_err;
        end else if ((r_state == RESP_FULL) && rready) begin
            w_state_nxt = RESP_EMPTY;
            w_data_nxt  = '0;
            w_err_nxt   = 1'b0;
        end
    end

    // Outputs: valid mirrors the FULL state, payload straight from registers
    always_comb begin
        rvalid = (r_state == RESP_FULL);
        rdata  = r_data;
        err    = r_err;
    end

endmodule : imem_resp_buf
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares the combinational imem read port between instruction
//            fetch (F) and debug/loader readback (D). Fixed priority F over D
//            with an anti-starvation wait counter, alignment checking and a
//            one-cycle registered response per port.
//            Build option IMEM_ARB_RR_EN: round-robin arbitration on a 1-bit
//            last-grant register replaces priority plus wait counter.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch port
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          f_rready,
    // debug port
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    input  logic          d_rready,
    // imem read port
    output logic [AW-1:0] im_addr,
    output logic          im_r,
    input  logic [DW-1:0] im_rd
);

    logic [1:0]    w_req;
    logic [1:0]    w_rready;
    logic [1:0]    w_rvalid;
    logic [1:0]    w_err;
    logic [DW-1:0] w_rdata [2];
    logic [1:0]    w_elig;
    logic [1:0]    w_gnt;
    logic          w_pick_d;
    logic          w_any_gnt;
    logic [AW-1:0] w_gnt_addr;
    logic          w_aligned;
    logic [DW-1:0] w_load_data;

    assign w_req[PORT_F]    = f_req;
    assign w_req[PORT_D]    = d_req;
    assign w_rready[PORT_F] = f_rready;
    assign w_rready[PORT_D] = d_rready;

    // A port can take a new access if its slot is empty or draining now
    assign w_elig = w_req & (~w_rvalid | w_rready);

`ifdef IMEM_ARB_RR_EN
    logic r_last_grant;

    // Remember which port won last so the other wins the next contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_F;
        end else if (w_any_gnt) begin
            r_last_grant <= w_gnt[PORT_D];
        end
    end

    assign w_pick_d = (r_last_grant == PORT_F);
`else
    localparam logic [WAIT_CW-1:0] c_max_wait = WAIT_CW'(MAX_WAIT);

    logic [WAIT_CW-1:0] r_wait_cnt;
    logic [WAIT_CW-1:0] w_wait_nxt;

    // Wait counter: count denied-but-eligible D cycles, clear on grant or idle
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (w_gnt[PORT_D] || !d_req) begin
            w_wait_nxt = '0;
        end else if (w_elig[PORT_D] && (r_wait_cnt != c_max_wait)) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign w_pick_d = (r_wait_cnt == c_max_wait);
`endif

    // Grant select: single eligible port wins, contention resolved by w_pick_d
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            if (w_elig[PORT_F] && w_elig[PORT_D]) begin
                if (w_pick_d) begin
                    w_gnt[PORT_D] = 1'b1;
                end else begin
                    w_gnt[PORT_F] = 1'b1;
                end
            end else if (w_elig[PORT_F]) begin
                w_gnt[PORT_F] = 1'b1;
            end else if (w_elig[PORT_D]) begin
                w_gnt[PORT_D] = 1'b1;
            end
        end
    end

    // Memory access: steer granted address, read only on word-aligned access
    always_comb begin
        w_any_gnt   = |w_gnt;
        w_gnt_addr  = w_gnt[PORT_D] ? d_addr : f_addr;
        w_aligned   = (w_gnt_addr[1:0] == 2'b00);
        im_addr     = w_any_gnt ? w_gnt_addr : '0;
        im_r        = w_any_gnt && w_aligned;
        w_load_data = w_aligned ? im_rd : '0;
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_port
            imem_resp_buf #(
                .DW (DW)
            ) u_resp_buf (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (w_gnt[g]),
                .load_data (w_load_data),
                .load_err  (~w_aligned),
                .rready    (w_rready[g]),
                .rvalid    (w_rvalid[g]),
                .rdata     (w_rdata[g]),
                .err       (w_err[g])
            );
        end
    endgenerate

    assign f_gnt    = w_gnt[PORT_F];
    assign d_gnt    = w_gnt[PORT_D];
    assign f_rvalid = w_rvalid[PORT_F];
    assign d_rvalid = w_rvalid[PORT_D];
    assign f_rdata  = w_rdata[PORT_F];
    assign d_rdata  = w_rdata[PORT_D];
    assign f_err    = w_err[PORT_F];
    assign d_err    = w_err[PORT_D];

endmodule : imem_arbiter
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Self-checking bench for imem_arbiter: a directed vector table
//            plus hand-written starvation and asynchronous reset sequences.
//            imem is modelled as word(a) = 0x2001_0001 + a[31:2].
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req, f_gnt, f_rvalid, f_err, f_rready;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_gnt, d_rvalid, d_err, d_rready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] im_addr;
    logic          im_r;
    logic [DW-1:0] im_rd;

    int checks = 0;
    int errors = 0;

    imem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .f_rready (f_rready),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .d_rready (d_rready),
        .im_addr  (im_addr),
        .im_r     (im_r),
        .im_rd    (im_rd)
    );

    always #5 clk = ~clk;

    // Combinational memory model
    assign im_rd = 32'h2001_0001 + {2'b00, im_addr[31:2]};

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h2001_0001 + {2'b00, a[31:2]};
    endfunction

    // All observable outputs in one vector
    logic [127:0] obs;
    assign obs = {25'd0, f_gnt, d_gnt, im_r, im_addr,
                  f_rvalid, f_rdata, f_err, d_rvalid, d_rdata, d_err};

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        frr;
        logic        dr;
        logic [31:0] da;
        logic        drr;
        logic        fg;
        logic        dg;
        logic        imr;
        logic [31:0] ima;
        logic        fv;
        logic [31:0] fd;
        logic        fe;
        logic        dv;
        logic [31:0] dd;
        logic        de;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic frr,
                         input logic dr, input logic [31:0] da, input logic drr);
        f_req    = fr;
        f_addr   = fa;
        f_rready = frr;
        d_req    = dr;
        d_addr   = da;
        d_rready = drr;
    endtask

    initial begin
        // Vector table: inputs for one cycle and the outputs seen mid-cycle
        //          fr  fa          frr  dr  da          drr  fg dg imr ima          fv  fd            fe  dv  dd            de
        vt[0] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vt[1] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vt[2] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0,         1'b0};
        vt[3] = '{1'b1, 32'h14, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0,         1'b0};
        vt[4] = '{1'b1, 32'h14, 1'b0, 1'b1, 32'h24, 1'b1, 1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h2001_0005, 1'b0, 1'b1, 32'h2001_0009, 1'b0};
        vt[5] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h2001_0005, 1'b0, 1'b1, 32'h2001_000A, 1'b0};
        vt[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h06, 1'b1, 1'b0, 1'b1, 1'b0, 32'h06, 1'b1, 32'h2001_0006, 1'b0, 1'b0, 32'h0,         1'b0};
        vt[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        vt[8] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};

        // Reset: requests asserted, yet no grant and no imem read
        drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 1'b1);
        repeat (2) @(negedge clk);
        check("reset_state", obs, 128'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].fr, vt[i].fa, vt[i].frr, vt[i].dr, vt[i].da, vt[i].drr);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs,
                  {25'd0, vt[i].fg, vt[i].dg, vt[i].imr, vt[i].ima,
                   vt[i].fv, vt[i].fd, vt[i].fe, vt[i].dv, vt[i].dd, vt[i].de});
            @(posedge clk);
            #1;
        end

        // Starvation: both request every cycle -> F,F,F,F,D repeating
        drive(1'b1, 32'h00, 1'b1, 1'b1, 32'h40, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("starve_gnt%0d", i), {126'd0, f_gnt, d_gnt},
                  (i % 5 == 4) ? 128'd1 : 128'd2);
            if (i == 5) begin
                check("starve_drsp", {95'd0, d_rvalid, d_rdata},
                      {95'd0, 1'b1, word(32'h40)});
            end
            @(posedge clk);
            #1;
        end

        // Fill both slots under backpressure (D slot still full from above)
        drive(1'b1, 32'h08, 1'b0, 1'b1, 32'h0C, 1'b0);
        @(negedge clk);
        check("bp_gnt", {126'd0, f_gnt, d_gnt}, 128'd2);
        check("bp_dhold", {96'd0, d_rdata}, {96'd0, word(32'h40)});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("both_full", {91'd0, f_rvalid, d_rvalid, f_gnt, d_gnt, im_r, f_rdata},
              {91'd0, 5'b11000, word(32'h08)});

        // Asynchronous reset mid-cycle with requests still asserted
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs, 128'd0);
        @(negedge clk);
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        #1;
        check("post_reset_gnt", {93'd0, f_gnt, d_gnt, im_r, im_addr},
              {93'd0, 3'b101, 32'h10});
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("post_reset_rsp", {94'd0, f_rvalid, f_err, f_rdata},
              {94'd0, 2'b10, 32'h2001_0005});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_arbiter
`default_nettype wire
